ahb_slave_if_gen: RTL and testbench

AHB_SLAVE_IF_GEN -- requirements
Module: ahb_slave_if_gen

---
 rtl/ahb_slave_if_gen.sv | 133 +++++++++++++
 tb/tb_ahb_slave_if_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if_gen.sv
// AHB-to-APB bridge slave front end: address decode, pipeline registers,
// and the transfer FSM with wait timeout and two-cycle ERROR response.
module ahb_slave_if_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_SLV = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hwrite,
  input  logic              hreadyin,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              apb_done,
  output logic              valid,
  output logic              hwrite_reg,
  output logic [ADDR_W-1:0] haddr1,
  output logic [ADDR_W-1:0] haddr2,
  output logic [DATA_W-1:0] hwdata1,
  output logic [DATA_W-1:0] hwdata2,
  output logic [NUM_SLV-1:0] temp_selx,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic [1:0]        hresp
);

  localparam int AW = ADDR_W + 4;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef logic [AW-1:0] wide_t;
  typedef enum logic [1:0] {IDLE, BUSY, ERR1, ERR2} state_t;

  // Widened by 4 bits so the top of the map cannot wrap.
  localparam wide_t LO = wide_t'(BASE_ADDR);
  localparam wide_t RS = wide_t'(REGION_SIZE);
  localparam wide_t HI = LO + wide_t'(NUM_SLV) * RS;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  state_t state;
  logic [CW-1:0] cnt;
  wide_t ha;
  logic in_range;
  logic accept;
  logic timeout;
  logic unused_htrans0;

  assign ha = wide_t'(haddr);
  assign in_range = (ha >= LO) && (ha < HI);
  assign accept = hreadyin && htrans[1] && (state == IDLE);
  assign valid = accept && in_range;
  assign timeout = (cnt == TLIM);
  assign unused_htrans0 = htrans[0];

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
    assign temp_selx[i] = (ha >= LO + wide_t'(i) * RS) &&
                          (ha < LO + wide_t'(i + 1) * RS);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr1 <= '0;
      haddr2 <= '0;
      hwdata1 <= '0;
      hwdata2 <= '0;
      hwrite_reg <= 1'b0;
    end else if (hreadyin) begin
      haddr1 <= haddr;
      haddr2 <= haddr1;
      hwdata1 <= hwdata;
      hwdata2 <= hwdata1;
      hwrite_reg <= hwrite;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE;
      cnt <= '0;
      hrdata <= '0;
      hreadyout <= 1'b1;
      hresp <= 2'b00;
    end else begin
      // Counter is zero whenever BUSY is entered.
      cnt <= (state == BUSY) ? cnt + CW'(1) : '0;
      case (state)
        IDLE: begin
          if (valid) begin
            state <= BUSY;
            hreadyout <= 1'b0;
            hresp <= 2'b00;
          end else if (accept) begin
            state <= ERR1;
            hreadyout <= 1'b0;
            hresp <= 2'b01;
          end
        end
        BUSY: begin
          if (apb_done) begin
            state <= IDLE;
            hreadyout <= 1'b1;
            hresp <= 2'b00;
            if (!hwrite_reg) hrdata <= prdata;
          end else if (timeout) begin
            state <= ERR1;
            hreadyout <= 1'b0;
            hresp <= 2'b01;
          end
        end
        ERR1: begin
          state <= ERR2;
          hreadyout <= 1'b1;
          hresp <= 2'b01;
        end
        ERR2: begin
          state <= IDLE;
          hreadyout <= 1'b1;
          hresp <= 2'b00;
        end
        default: begin
          state <= IDLE;
          hreadyout <= 1'b1;
          hresp <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// Random plus directed stimulus for ahb_slave_if_gen, compared each
// cycle against a transaction-level reference model.
module tb_ahb_slave_if_gen;

  localparam longint BASE = 64'h8000_0000;
  localparam longint RS = 64'h0400_0000;
  localparam int NSLV = 3;
  localparam int TMO = 16;

  logic hclk = 1'b0;
  logic hreset, hwrite, hreadyin, apb_done;
  logic [1:0] htrans;
  logic [31:0] haddr, hwdata, prdata;
  logic valid, hwrite_reg, hreadyout;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2, hrdata;
  logic [2:0] temp_selx;
  logic [1:0] hresp;

  int n_vec = 0;
  int n_err = 0;

  bit m_busy;
  int m_age;
  int m_err;
  logic [31:0] m_hrdata, m_a1, m_a2, m_d1, m_d2;
  logic m_hw;

  always #5 hclk = ~hclk;

  ahb_slave_if_gen dut (
    .hclk(hclk), .hreset(hreset), .hwrite(hwrite),
    .hreadyin(hreadyin), .htrans(htrans), .haddr(haddr),
    .hwdata(hwdata), .prdata(prdata), .apb_done(apb_done),
    .valid(valid), .hwrite_reg(hwrite_reg),
    .haddr1(haddr1), .haddr2(haddr2),
    .hwdata1(hwdata1), .hwdata2(hwdata2),
    .temp_selx(temp_selx), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic void region(input logic [31:0] a, output bit inr,
                                 output int idx);
    longint v;
    v = longint'({32'h0, a});
    inr = 0;
    idx = 0;
    if (v >= BASE) begin
      idx = int'((v - BASE) / RS);
      inr = idx < NSLV;
    end
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_age = 0;
    m_err = 0;
    m_hrdata = '0;
    m_a1 = '0;
    m_a2 = '0;
    m_d1 = '0;
    m_d2 = '0;
    m_hw = 0;
  endtask

  // Apply inputs (at negedge) and compare every output against the model.
  task automatic drive(input logic rst, input logic hw, input logic hr,
                       input logic [1:0] tr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pd,
                       input logic done);
    bit inr;
    int idx;
    bit idle;
    hreset = rst;
    hwrite = hw;
    hreadyin = hr;
    htrans = tr;
    haddr = a;
    hwdata = wd;
    prdata = pd;
    apb_done = done;
    #1;
    region(a, inr, idx);
    idle = !m_busy && (m_err == 0);
    chk("valid", valid, idle && hr && tr[1] && inr);
    chk("temp_selx", temp_selx, inr ? (3'b001 << idx) : 3'b000);
    chk("hreadyout", hreadyout, !m_busy && (m_err != 2));
    chk("hresp", hresp, (m_err != 0) ? 2'b01 : 2'b00);
    chk("hrdata", hrdata, m_hrdata);
    chk("haddr1", haddr1, m_a1);
    chk("haddr2", haddr2, m_a2);
    chk("hwdata1", hwdata1, m_d1);
    chk("hwdata2", hwdata2, m_d2);
    chk("hwrite_reg", hwrite_reg, m_hw);
  endtask

  // Advance the model by the rules for one clock, then clock the DUT.
  task automatic tick();
    bit inr;
    int idx;
    region(haddr, inr, idx);
    if (hreset) begin
      model_reset();
    end else begin
      if (m_err > 0) begin
        m_err--;
      end else if (m_busy) begin
        if (apb_done) begin
          m_busy = 0;
          if (!m_hw) m_hrdata = prdata;
        end else if (m_age == TMO - 1) begin
          m_busy = 0;
          m_err = 2;
        end else begin
          m_age++;
        end
      end else if (hreadyin && htrans[1]) begin
        if (inr) begin
          m_busy = 1;
          m_age = 0;
        end else begin
          m_err = 2;
        end
      end
      if (hreadyin) begin
        m_a2 = m_a1;
        m_a1 = haddr;
        m_d2 = m_d1;
        m_d1 = hwdata;
        m_hw = hwrite;
      end
    end
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic idle_cyc(input logic done, input logic [31:0] pd);
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, pd, done);
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0: a = $urandom;
      1: a = 32'(BASE + longint'($urandom_range(0, 32'h0FFF_FFFF)));
      2: begin
        a = 32'(BASE + longint'($urandom_range(0, 3)) * RS);
        if ($urandom_range(0, 1) == 1) a = a - 32'd1;
      end
      default: a = 32'(BASE) - $urandom_range(1, 16);
    endcase
    return a;
  endfunction

  initial begin
    hreset = 1;
    hwrite = 0;
    hreadyin = 1;
    htrans = 0;
    haddr = 0;
    hwdata = 0;
    prdata = 0;
    apb_done = 0;
    model_reset();
    repeat (2) @(posedge hclk);
    @(negedge hclk);

    drive(1, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    tick();
    chk("rst_rdy", {hreadyout, hresp}, 3'b100);

    // Mapped read, data returned after three wait cycles.
    drive(0, 0, 1, 2'b10, 32'h8400_0010, 32'h0, 32'h0, 0);
    chk("rd_valid", valid, 1'b1);
    chk("rd_sel", temp_selx, 3'b010);
    tick();
    idle_cyc(0, 32'h0);
    idle_cyc(0, 32'h0);
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 32'hDEAD_BEEF, 1);
    chk("rd_wait", hreadyout, 1'b0);
    tick();
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    chk("rd_data", hrdata, 32'hDEAD_BEEF);
    chk("rd_ready", hreadyout, 1'b1);
    tick();

    // Top of the map, then first unmapped address.
    drive(0, 0, 1, 2'b10, 32'h8BFF_FFFF, 32'h0, 32'h0, 0);
    chk("hi_sel", temp_selx, 3'b100);
    tick();
    idle_cyc(1, 32'h1234_5678);
    drive(0, 0, 1, 2'b10, 32'h8C00_0000, 32'h0, 32'h0, 0);
    chk("oor_sel", temp_selx, 3'b000);
    chk("oor_valid", valid, 1'b0);
    tick();
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 1);
    chk("err1", {hreadyout, hresp}, 3'b001);
    tick();
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    chk("err2", {hreadyout, hresp}, 3'b101);
    tick();

    // Transfer type qualification.
    drive(0, 0, 1, 2'b00, 32'h8000_0100, 32'h0, 32'h0, 0);
    chk("idle_tr", valid, 1'b0);
    tick();
    drive(0, 0, 1, 2'b01, 32'h8000_0100, 32'h0, 32'h0, 0);
    chk("busy_tr", valid, 1'b0);
    tick();
    drive(0, 1, 1, 2'b11, 32'h8000_0100, 32'hA5A5_0001, 32'h0, 0);
    chk("seq_tr", valid, 1'b1);
    tick();
    idle_cyc(1, 32'hFFFF_0000);

    // Write timeout: sixteen wait cycles then ERROR.
    drive(0, 1, 1, 2'b10, 32'h8000_0004, 32'h1111_2222, 32'h0, 0);
    tick();
    for (int i = 0; i < TMO; i++) begin
      drive(0, 1, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
      chk("to_wait", hreadyout, 1'b0);
      tick();
    end
    drive(0, 1, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    chk("to_err1", {hreadyout, hresp}, 3'b001);
    tick();
    drive(0, 1, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    chk("to_err2", {hreadyout, hresp}, 3'b101);
    tick();

    // Completion on the last permitted wait cycle.
    drive(0, 1, 1, 2'b10, 32'h8000_0008, 32'h3333_4444, 32'h0, 0);
    tick();
    for (int i = 0; i < TMO - 1; i++) begin
      drive(0, 1, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
      tick();
    end
    drive(0, 1, 1, 2'b00, 32'h0, 32'h0, 32'h0, 1);
    tick();
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    chk("last_ok", {hreadyout, hresp}, 3'b100);
    tick();

    // Pipeline stall.
    drive(0, 0, 1, 2'b00, 32'h0000_00A0, 32'h0000_0DA0, 32'h0, 0);
    tick();
    drive(0, 0, 1, 2'b00, 32'h0000_00B0, 32'h0000_0DB0, 32'h0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 2'b00, 32'h0000_00C0, 32'h0000_0DC0, 32'h0, 0);
      chk("stall_a1", haddr1, 32'h0000_00B0);
      chk("stall_a2", haddr2, 32'h0000_00A0);
      tick();
    end
    drive(0, 0, 1, 2'b00, 32'h0000_00C0, 32'h0000_0DC0, 32'h0, 0);
    tick();
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    chk("resume_a1", haddr1, 32'h0000_00C0);
    chk("resume_d2", hwdata2, 32'h0000_0DB0);
    tick();

    // Reset during BUSY.
    drive(0, 0, 1, 2'b10, 32'h8800_0000, 32'h0, 32'h0, 0);
    tick();
    drive(1, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 1);
    tick();
    drive(0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 0);
    chk("rst_busy", {hreadyout, hresp}, 3'b100);
    chk("rst_a1", haddr1, 32'h0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, 1'($urandom),
            $urandom_range(0, 9) != 0, 2'($urandom), rand_addr(),
            $urandom, $urandom, $urandom_range(0, 6) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
